// File: rtl/audio_sample_sched.sv
// Sample-rate scheduler: two producers arbitrate round-robin into a stereo FIFO,
// and a divider tick pops one sample per period to the DAC. Option: AUDIO_SCHED_UNDERRUN_HOLD_EN.
module audio_sample_sched #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int DIV        = 1134
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [WIDTH-1:0]      req0_l,
  input  logic [WIDTH-1:0]      req0_r,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [WIDTH-1:0]      req1_l,
  input  logic [WIDTH-1:0]      req1_r,
  output logic                  dac_valid,
  input  logic                  dac_ready,
  output logic [WIDTH-1:0]      dac_l,
  output logic [WIDTH-1:0]      dac_r,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  underrun,
  output logic                  late
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {IDLE, PRESENT} state_t;

  logic [CNT_W-1:0]      count_reg;
  logic                  tick;
  logic                  rr_reg;
  logic [1:0]            valid_vec;
  logic [1:0]            grant_vec;
  logic [1:0]            ready_vec;
  logic [2*WIDTH-1:0]    prod_data [2];
  logic [2*WIDTH-1:0]    wr_data;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [2*WIDTH-1:0]    mem [DEPTH];
  logic [2*WIDTH-1:0]    head;
  logic [2*WIDTH-1:0]    underrun_data;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  state_t                state_reg;
  logic                  dac_valid_reg;
  logic [WIDTH-1:0]      dac_l_reg;
  logic [WIDTH-1:0]      dac_r_reg;
  logic                  underrun_reg;
  logic                  late_reg;

  // Sample period divider; the tick is free-running and ignores handshakes.
  assign tick = (count_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= tick ? '0 : count_reg + CNT_ONE;
    end
  end

  assign valid_vec    = {req1_valid, req0_valid};
  assign prod_data[0] = {req0_l, req0_r};
  assign prod_data[1] = {req1_l, req1_r};

  // Preferred producer wins if it is valid; otherwise the other one may take the slot.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_arb
      assign grant_vec[gi] = valid_vec[gi] & ((rr_reg == 1'(gi)) | ~valid_vec[1-gi]);
      assign ready_vec[gi] = grant_vec[gi] & ~full & ~reset;
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign push       = |ready_vec;
  assign wr_data    = grant_vec[1] ? prod_data[1] : prod_data[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_reg <= 1'b0;
    end else if (push) begin
      rr_reg <= ~grant_vec[1] ? 1'b1 : 1'b0;
    end
  end

  assign full  = (level_reg == LVL_FULL);
  assign empty = (level_reg == '0);
  assign pop   = tick & (state_reg == IDLE) & ~empty;
  assign head  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_ONE;
        2'b01:   level_reg <= level_reg - LVL_ONE;
        default: level_reg <= level_reg;
      endcase
    end
  end

`ifdef AUDIO_SCHED_UNDERRUN_HOLD_EN
  logic [2*WIDTH-1:0] last_reg;

  // Remembers the most recent real sample so an underrun repeats it instead of clicking to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg <= '0;
    end else if (pop) begin
      last_reg <= head;
    end
  end

  assign underrun_data = last_reg;
`else
  assign underrun_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      dac_valid_reg <= 1'b0;
      dac_l_reg     <= '0;
      dac_r_reg     <= '0;
      underrun_reg  <= 1'b0;
      late_reg      <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;
      late_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tick) begin
            dac_valid_reg <= 1'b1;
            state_reg     <= PRESENT;
            if (!empty) begin
              {dac_l_reg, dac_r_reg} <= head;
            end else begin
              {dac_l_reg, dac_r_reg} <= underrun_data;
              underrun_reg           <= 1'b1;
            end
          end
        end
        PRESENT: begin
          // A tick here is dropped, even when it coincides with the accept.
          if (tick) begin
            late_reg <= 1'b1;
          end
          if (dac_ready) begin
            dac_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dac_valid  = dac_valid_reg;
  assign dac_l      = dac_l_reg;
  assign dac_r      = dac_r_reg;
  assign underrun   = underrun_reg;
  assign late       = late_reg;
  assign fifo_level = level_reg;

endmodule

// File: tb/tb_audio_sample_sched.sv
// Directed bench for audio_sample_sched with DIV=8, DEPTH_LOG2=2.
module tb_audio_sample_sched;

  localparam int WIDTH      = 16;
  localparam int DEPTH_LOG2 = 2;
  localparam int DIV        = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                req0_valid, req0_ready;
  logic [WIDTH-1:0]    req0_l, req0_r;
  logic                req1_valid, req1_ready;
  logic [WIDTH-1:0]    req1_l, req1_r;
  logic                dac_valid, dac_ready;
  logic [WIDTH-1:0]    dac_l, dac_r;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                underrun, late;

  int checks = 0;
  int errors = 0;

  audio_sample_sched #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_l     (req0_l),
    .req0_r     (req0_r),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_l     (req1_l),
    .req1_r     (req1_r),
    .dac_valid  (dac_valid),
    .dac_ready  (dac_ready),
    .dac_l      (dac_l),
    .dac_r      (dac_r),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .late       (late)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] hold_l, hold_r;
`ifdef AUDIO_SCHED_UNDERRUN_HOLD_EN
    hold_l = 16'h7FFF;
    hold_r = 16'h8000;
`else
    hold_l = 16'h0000;
    hold_r = 16'h0000;
`endif
    reset = 1'b1; dac_ready = 1'b0;
    req0_valid = 1'b1; req0_l = '0; req0_r = '0;
    req1_valid = 1'b0; req1_l = '0; req1_r = '0;
    edges(3);
    chk("rst_valid", dac_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_late", late, 0);
    chk("rst_dac_l", dac_l, 0);
    chk("rst_ready0", req0_ready, 0);
    $display("reset: dac_valid=%0d level=%0d", dac_valid, fifo_level);
    req0_valid = 1'b0; reset = 1'b0; dac_ready = 1'b1;

    // Idle: underrun at every tick
    edges(7);  chk("e7_valid", dac_valid, 0);
    edges(1);  chk("e8_valid", dac_valid, 1); chk("e8_underrun", underrun, 1);
    chk("e8_dac_l", dac_l, 0); chk("e8_dac_r", dac_r, 0);
    $display("tick1: valid=%0d underrun=%0d l=%h r=%h", dac_valid, underrun, dac_l, dac_r);
    edges(1);  chk("e9_valid", dac_valid, 0); chk("e9_underrun", underrun, 0);
    edges(7);  chk("e16_valid", dac_valid, 1); chk("e16_underrun", underrun, 1);
    $display("tick2: valid=%0d underrun=%0d", dac_valid, underrun);

    // Single push from producer 0
    edges(1);
    req0_valid = 1'b1; req0_l = 16'h1111; req0_r = 16'h2222;
    #1; chk("push1_ready0", req0_ready, 1); chk("push1_ready1", req1_ready, 0);
    edges(1);  chk("e18_level", fifo_level, 1);
    req0_valid = 1'b0;
    edges(5);  chk("e23_level", fifo_level, 1); chk("e23_valid", dac_valid, 0);
    edges(1);  chk("e24_valid", dac_valid, 1); chk("e24_dac_l", dac_l, 16'h1111);
    chk("e24_dac_r", dac_r, 16'h2222); chk("e24_underrun", underrun, 0);
    chk("e24_level", fifo_level, 0);
    $display("pop1: l=%h r=%h level=%0d", dac_l, dac_r, fifo_level);
    edges(1);  chk("e25_valid", dac_valid, 0);

    // Push extreme sample, then run empty to see the underrun sample
    req0_valid = 1'b1; req0_l = 16'h7FFF; req0_r = 16'h8000;
    #1; chk("push2_ready0", req0_ready, 1);
    edges(1);  chk("e26_level", fifo_level, 1);
    req0_valid = 1'b0;
    edges(6);  chk("e32_dac_l", dac_l, 16'h7FFF); chk("e32_dac_r", dac_r, 16'h8000);
    chk("e32_level", fifo_level, 0);
    $display("pop2: l=%h r=%h", dac_l, dac_r);
    edges(1);  chk("e33_valid", dac_valid, 0);
    edges(7);  chk("e40_underrun", underrun, 1); chk("e40_valid", dac_valid, 1);
    chk("e40_dac_l", dac_l, hold_l); chk("e40_dac_r", dac_r, hold_r);
    $display("underrun sample: l=%h r=%h", dac_l, dac_r);
    edges(1);  chk("e41_valid", dac_valid, 0);

    // Both producers continuously valid; rr currently prefers producer 1
    req0_valid = 1'b1; req0_l = 16'h1000; req0_r = 16'h1001;
    req1_valid = 1'b1; req1_l = 16'h2000; req1_r = 16'h2001;
    #1; chk("arb0_ready1", req1_ready, 1); chk("arb0_ready0", req0_ready, 0);
    edges(1);  chk("e42_level", fifo_level, 1); chk("e42_ready0", req0_ready, 1);
    chk("e42_ready1", req1_ready, 0);
    edges(1);  chk("e43_level", fifo_level, 2); chk("e43_ready1", req1_ready, 1);
    edges(1);  chk("e44_level", fifo_level, 3); chk("e44_ready0", req0_ready, 1);
    edges(1);  chk("e45_level", fifo_level, 4); chk("e45_ready0", req0_ready, 0);
    chk("e45_ready1", req1_ready, 0);
    edges(2);  chk("e47_level", fifo_level, 4); chk("e47_ready0", req0_ready, 0);
    chk("e47_ready1", req1_ready, 0);
    edges(1);  chk("e48_level", fifo_level, 3); chk("e48_valid", dac_valid, 1);
    chk("e48_dac_l", dac_l, 16'h2000); chk("e48_dac_r", dac_r, 16'h2001);
    chk("e48_ready1", req1_ready, 1);
    $display("full pop: l=%h level=%0d ready1=%0d", dac_l, fifo_level, req1_ready);
    req0_valid = 1'b0; req1_valid = 1'b0; dac_ready = 1'b0;

    // Stalled consumer: late pulses, FIFO untouched
    edges(7);  chk("e55_late", late, 0); chk("e55_valid", dac_valid, 1);
    edges(1);  chk("e56_late", late, 1); chk("e56_level", fifo_level, 3);
    chk("e56_dac_l", dac_l, 16'h2000); chk("e56_valid", dac_valid, 1);
    $display("late1: late=%0d level=%0d", late, fifo_level);
    edges(1);  chk("e57_late", late, 0);
    edges(7);  chk("e64_late", late, 1); chk("e64_level", fifo_level, 3);
    chk("e64_dac_r", dac_r, 16'h2001);
    edges(7);
    dac_ready = 1'b1;
    edges(1);  chk("e72_late", late, 1); chk("e72_valid", dac_valid, 0);
    chk("e72_level", fifo_level, 3);
    $display("accept on tick: late=%0d valid=%0d", late, dac_valid);
    dac_ready = 1'b0;
    edges(1);  chk("e73_late", late, 0); chk("e73_valid", dac_valid, 0);
    edges(7);  chk("e80_valid", dac_valid, 1); chk("e80_dac_l", dac_l, 16'h1000);
    chk("e80_level", fifo_level, 2); chk("e80_underrun", underrun, 0);
    req0_valid = 1'b1;
    #1; chk("e80_ready0", req0_ready, 1);
    edges(1);  chk("e81_level", fifo_level, 3); chk("e81_valid", dac_valid, 1);
    req0_valid = 1'b0;

    // Mid-operation reset
    reset = 1'b1;
    edges(1);  chk("mrst_level", fifo_level, 0); chk("mrst_valid", dac_valid, 0);
    chk("mrst_dac_l", dac_l, 0);
    $display("mid reset: level=%0d valid=%0d", fifo_level, dac_valid);
    reset = 1'b0;
    edges(7);  chk("f7_valid", dac_valid, 0);
    edges(1);  chk("f8_valid", dac_valid, 1); chk("f8_underrun", underrun, 1);
    chk("f8_dac_l", dac_l, 0); chk("f8_level", fifo_level, 0);
    $display("post reset tick: valid=%0d underrun=%0d l=%h", dac_valid, underrun, dac_l);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
